// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and strobe constants for the load/store unit
// Purpose: common definitions imported by lsu_align and load_store_unit.
// Ports: none (package).
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_bus_if.sv
// rtl/lsu_bus_if.sv - valid/ready word data bus between the load/store unit and the SoC
// Purpose: bundles the data-bus handshake, address, strobes and data.
// Ports (master view): bus_valid/bus_we/bus_addr/bus_wstrb/bus_wdata out;
//                      bus_ready/bus_rdata/bus_error in. Slave view is the mirror.
interface lsu_bus_if;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_error;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rdata, bus_error
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rdata, bus_error
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational width decode, store lane steering and load extension
// Purpose: turns funct3 + byte offset into strobes/replicated store data and
//   width/alignment faults; extracts and extends the addressed lane of a read word.
// Ports: is_store, funct3, off, wdata in -> wstrb, wlanes, bad_width, misaligned out;
//        ld_funct3, ld_off, rdata_word in -> ld_data out.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wlanes,
  output logic        bad_width,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata_word,
  output logic [31:0] ld_data
);
  logic [31:0] lane;

  always_comb begin
    wstrb      = STRB_NONE;
    wlanes     = wdata;
    bad_width  = 1'b0;
    misaligned = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wstrb  = STRB_B << off;
          wlanes = {4{wdata[7:0]}};
        end
        F3_SH: begin
          wstrb  = STRB_H << {off[1], 1'b0};
          wlanes = {2{wdata[15:0]}};
        end
        F3_SW:   wstrb = STRB_W;
        default: bad_width = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad_width = 1'b0;
        default:                             bad_width = 1'b1;
      endcase
    end
    // Low two funct3 bits give the access size for both loads and stores.
    case (funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    lane = rdata_word >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  ld_data = {24'h0, lane[7:0]};
      F3_LHU:  ld_data = {16'h0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - stalls the core while a load/store runs on the valid/ready data bus
// Purpose: IDLE -> BUS -> RESP sequencer with bus timeout and fault reporting.
// Ports: clock, reset (async, active low); req_read, req_write, funct3, addr, wdata in;
//        stall, rdata, fault out; bus (lsu_bus_if.master) to the SoC data bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int BITSIZE        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_read,
  input  logic               req_write,
  input  logic [2:0]         funct3,
  input  logic [BITSIZE-1:0] addr,
  input  logic [BITSIZE-1:0] wdata,
  output logic               stall,
  output logic [BITSIZE-1:0] rdata,
  output logic               fault,
  lsu_bus_if.master          bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state, state_d;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q, fault_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_off_q;

  logic        req, illegal, bad_width, misaligned;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wlanes, ld_data;

  lsu_align u_align (
    .is_store   (req_write),
    .funct3     (funct3),
    .off        (addr[1:0]),
    .wdata      (wdata),
    .wstrb      (al_wstrb),
    .wlanes     (al_wlanes),
    .bad_width  (bad_width),
    .misaligned (misaligned),
    .ld_funct3  (ld_f3_q),
    .ld_off     (ld_off_q),
    .rdata_word (bus.bus_rdata),
    .ld_data    (ld_data)
  );

  assign req     = req_read | req_write;
  assign illegal = (req_read & req_write) | bad_width | misaligned;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    stall   = 1'b0;
    case (state)
      ST_IDLE: if (req) begin
        stall   = 1'b1;
        state_d = illegal ? ST_RESP : ST_BUS;
      end
      ST_BUS: begin
        stall = 1'b1;
        if (bus.bus_ready || (cnt == CNT_LAST)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A request held during reset must not freeze the core.
    if (!reset) stall = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wstrb_q  <= STRB_NONE;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      ld_f3_q  <= 3'b000;
      ld_off_q <= 2'b00;
    end else begin
      fault_q <= 1'b0;
      case (state)
        ST_IDLE: if (req) begin
          cnt <= '0;
          if (illegal) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
          end else begin
            addr_q   <= {addr[31:2], 2'b00};
            we_q     <= req_write;
            wstrb_q  <= req_write ? al_wstrb : STRB_NONE;
            wdata_q  <= al_wlanes;
            ld_f3_q  <= funct3;
            ld_off_q <= addr[1:0];
          end
        end
        ST_BUS: begin
          if (bus.bus_ready) begin
            rdata_q <= ld_data;
            fault_q <= bus.bus_error;
          end else if (cnt == CNT_LAST) begin
            rdata_q <= '0;
            fault_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Valid follows the state register so an async reset drops it at once.
  assign bus.bus_valid = (state == ST_BUS);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_wdata = wdata_q;
  assign rdata         = rdata_q;
  assign fault         = fault_q;
endmodule
